// File: rtl/sdm_pkg.sv
// ============================================================================
// sdm_pkg - shared types, constants and output scaling for the sinc^3 decimator. Rev 1.0
// ============================================================================
`default_nettype none

package sdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int OUT_WIDTH = 16;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } dec_state_t;

  // Positive shift = arithmetic right shift, negative = left shift; result clamped to OUT_WIDTH.
  function automatic logic signed [OUT_WIDTH-1:0] scale_sat(input logic signed [63:0] acc,
                                                            input int shift);
    logic signed [63:0] v;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (OUT_WIDTH - 1));
    if (shift >= 0) begin
      v = acc >>> shift;
    end else begin
      v = acc <<< (-shift);
    end
    if (v > max_v) begin
      v = max_v;
    end else if (v < min_v) begin
      v = min_v;
    end
    return v[OUT_WIDTH-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_integrator_chain.sv
// ============================================================================
// cic_integrator_chain - three enabled, wrapping integrators in cascade. Rev 1.0
// ============================================================================
`default_nettype none

module cic_integrator_chain #(
  parameter int W = 20
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         EN,
  input  logic [W-1:0] X,
  output logic [W-1:0] I3
);

  logic [W-1:0] i1;
  logic [W-1:0] i2;

  // Each stage consumes the previous-cycle value of its predecessor; overflow wraps by design.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      i1 <= '0;
      i2 <= '0;
      I3 <= '0;
    end else if (EN) begin
      i1 <= i1 + X;
      i2 <= i2 + i1;
      I3 <= I3 + i2;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sigma_delta_decimator.sv
// ============================================================================
// sigma_delta_decimator - sinc^3 CIC decimator turning a 1-bit stream into 16-bit words. Rev 1.0
// ============================================================================
`default_nettype none

module sigma_delta_decimator
  import sdm_pkg::*;
#(
  parameter int DECIMATION = 64,
  parameter int LOG2_R     = $clog2(DECIMATION),
  parameter int ACC_WIDTH  = 2 + CIC_ORDER * LOG2_R
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 DATA_IN,
  input  logic                 DATA_VALID,
  output logic [OUT_WIDTH-1:0] DATAWORD_OUT,
  output logic                 WORD_VALID,
  input  logic                 WORD_READY,
  output logic                 OVERRUN
);

  localparam int              SHIFT    = CIC_ORDER * LOG2_R - (OUT_WIDTH - 1);
  localparam logic [LOG2_R-1:0] LAST_BIT = LOG2_R'(DECIMATION - 1);

  logic [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH-1:0] i3;
  logic [LOG2_R-1:0]    bit_cnt;
  logic [ACC_WIDTH-1:0] sample;
  logic                 strobe;
  logic [ACC_WIDTH-1:0] s_d;
  logic [ACC_WIDTH-1:0] c1_d;
  logic [ACC_WIDTH-1:0] c2_d;
  logic [ACC_WIDTH-1:0] c1;
  logic [ACC_WIDTH-1:0] c2;
  logic [ACC_WIDTH-1:0] c3;
  logic signed [OUT_WIDTH-1:0] word;
  dec_state_t           state;
  logic [1:0]           fill_cnt;

  // Bit 0 means +1, bit 1 means -1.
  assign x = DATA_IN ? {ACC_WIDTH{1'b1}} : ACC_WIDTH'(1);

  cic_integrator_chain #(
    .W(ACC_WIDTH)
  ) u_integrators (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .EN   (DATA_VALID),
    .X    (x),
    .I3   (i3)
  );

  assign c1   = sample - s_d;
  assign c2   = c1 - c1_d;
  assign c3   = c2 - c2_d;
  assign word = scale_sat({{(64 - ACC_WIDTH){c3[ACC_WIDTH-1]}}, c3}, SHIFT);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt      <= '0;
      sample       <= '0;
      strobe       <= 1'b0;
      s_d          <= '0;
      c1_d         <= '0;
      c2_d         <= '0;
      state        <= FILL;
      fill_cnt     <= 2'd0;
      DATAWORD_OUT <= '0;
      WORD_VALID   <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (DATA_VALID) begin
        bit_cnt <= bit_cnt + LOG2_R'(1);
        if (bit_cnt == LAST_BIT) begin
          sample <= i3;
          strobe <= 1'b1;
        end
      end

      if (strobe) begin
        s_d  <= sample;
        c1_d <= c1;
        c2_d <= c2;
        case (state)
          FILL: begin
            // Startup words carry comb-delay transients and are discarded.
            fill_cnt <= fill_cnt + 2'd1;
            if (fill_cnt == 2'd2) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (!WORD_VALID || WORD_READY) begin
              DATAWORD_OUT <= word;
              WORD_VALID   <= 1'b1;
            end else begin
              OVERRUN <= 1'b1;
            end
          end
          default: state <= FILL;
        endcase
      end else if (WORD_VALID && WORD_READY) begin
        WORD_VALID <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sigma_delta_decimator.sv
// ============================================================================
// tb_sigma_delta_decimator - randomized bench with a closed-form sinc^3 reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_sigma_delta_decimator;

  localparam int R = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        dv = 1'b0;
  logic        rdy = 1'b0;
  logic [15:0] dout;
  logic        wvalid;
  logic        ovr;

  int          bits[$];
  logic [15:0] got[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  sigma_delta_decimator #(
    .DECIMATION(R)
  ) dut (
    .CLOCK       (clk),
    .RESET       (rst_n),
    .DATA_IN     (din),
    .DATA_VALID  (dv),
    .DATAWORD_OUT(dout),
    .WORD_VALID  (wvalid),
    .WORD_READY  (rdy),
    .OVERRUN     (ovr)
  );

  // Third integrator after n accepted samples: sum of x_k * C(n-1-k, 2).
  function automatic longint i3_after(int n);
    longint s = 0;
    for (int k = 0; k <= n - 3; k++) begin
      longint a = longint'(n - 1 - k);
      longint w = a * (a - 1) / 2;
      s += (bits[k] != 0) ? -w : w;
    end
    return s;
  endfunction

  // Decimated word j: third difference of I3 sampled just before the last bit of each frame.
  function automatic logic [15:0] model_word(int j);
    longint coef[4] = '{1, -3, 3, -1};
    longint c = 0;
    for (int m = 0; m < 4; m++) begin
      if (j - m >= 0) c += coef[m] * i3_after((j - m) * R + R - 1);
    end
    c = c >>> 3;
    if (c > 32767) c = 32767;
    if (c < -32768) c = -32768;
    return c[15:0];
  endfunction

  task automatic step(input logic b, input logic v, input logic r);
    logic        pv;
    logic [15:0] pd;
    din = b;
    dv  = v;
    rdy = r;
    pv  = wvalid;
    pd  = dout;
    @(posedge clk);
    if (v) bits.push_back(int'(b));
    if (pv && r) got.push_back(pd);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    din = 1'b0;
    dv  = 1'b0;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bits.delete();
    got.delete();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", dout); end
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", wvalid); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", ovr); end
    apply_reset();
  endtask

  task automatic test_pattern(input int kind, input logic [15:0] exp_word);
    apply_reset();
    for (int i = 0; i < 520; i++) begin
      logic b;
      case (kind)
        0:       b = 1'b0;
        1:       b = 1'b1;
        2:       b = (i % 2) != 0;
        default: b = (i % 4) == 3;
      endcase
      step(b, 1'b1, 1'b1);
      if (i == 255) begin
        checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL latency_early kind=%0d got=%b exp=0", kind, wvalid); end
      end
      if (i == 256) begin
        checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL latency_first kind=%0d got=%b exp=1", kind, wvalid); end
      end
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL word_count kind=%0d got=%0d exp=5", kind, got.size()); end
    foreach (got[k]) begin
      checks++; if (got[k] !== exp_word) begin errors++; $display("FAIL pattern_word kind=%0d idx=%0d got=%h exp=%h", kind, k, got[k], exp_word); end
    end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL pattern_overrun kind=%0d got=%b exp=0", kind, ovr); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 11 * R + 4; i++) step(1'($urandom % 2), 1'b1, 1'b1);
    checks++; if (got.size() != 8) begin errors++; $display("FAIL random_count got=%0d exp=8", got.size()); end
    foreach (got[k]) begin
      checks++; if (got[k] !== model_word(k + 3)) begin errors++; $display("FAIL random_word idx=%0d got=%h exp=%h", k, got[k], model_word(k + 3)); end
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    for (int s = 1; s <= 384; s++) begin
      step(1'($urandom % 2), 1'b1, 1'b0);
      if (s == 257) begin
        checks++; if (wvalid !== 1'b1 || dout !== model_word(3)) begin errors++; $display("FAIL hold_first valid=%b data=%h exp=1/%h", wvalid, dout, model_word(3)); end
      end
      if (s == 321) begin
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", ovr); end
        checks++; if (wvalid !== 1'b1 || dout !== model_word(3)) begin errors++; $display("FAIL overrun_keep valid=%b data=%h exp=1/%h", wvalid, dout, model_word(3)); end
      end
    end
    step(1'($urandom % 2), 1'b1, 1'b1);
    checks++; if (wvalid !== 1'b1) begin errors++; $display("FAIL same_edge_valid got=%b exp=1", wvalid); end
    checks++; if (dout !== model_word(5)) begin errors++; $display("FAIL same_edge_data got=%h exp=%h", dout, model_word(5)); end
    checks++; if (got.size() != 1 || got[0] !== model_word(3)) begin errors++; $display("FAIL accepted_old count=%0d exp=1 word=%h", got.size(), model_word(3)); end
    step(1'($urandom % 2), 1'b1, 1'b1);
    checks++; if (wvalid !== 1'b0) begin errors++; $display("FAIL valid_drop got=%b exp=0", wvalid); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", ovr); end
  endtask

  task automatic test_reset_midframe();
    int  cycles;
    logic early;
    apply_reset();
    while (bits.size() < 300) step(1'($urandom % 2), 1'($urandom % 2), 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dout !== 16'h0000 || wvalid !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL async_reset data=%h valid=%b ovr=%b exp=0000/0/0", dout, wvalid, ovr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bits.delete();
    got.delete();
    cycles = 0;
    early  = 1'b0;
    while (bits.size() < 8 * R && cycles < 4000) begin
      step(1'($urandom % 2), 1'($urandom % 2), 1'b1);
      if (wvalid && bits.size() < 4 * R) early = 1'b1;
      cycles++;
    end
    checks++; if (cycles >= 4000) begin errors++; $display("FAIL gap_timeout bits=%0d exp=%0d", bits.size(), 8 * R); end
    repeat (4) step(1'b0, 1'b0, 1'b1);
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL refill_early got=%b exp=0", early); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL gap_count got=%0d exp=5", got.size()); end
    foreach (got[k]) begin
      checks++; if (got[k] !== model_word(k + 3)) begin errors++; $display("FAIL gap_word idx=%0d got=%h exp=%h", k, got[k], model_word(k + 3)); end
    end
  endtask

  initial begin
    test_reset();
    test_pattern(0, 16'h7FFF);
    test_pattern(1, 16'h8000);
    test_pattern(2, 16'h0000);
    test_pattern(3, 16'h4000);
    test_random();
    test_overrun();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
